// File: rtl/uart_cmd_decoder.sv
// Framed command decoder behind uart_rx: parses A5/cmd/~cmd packets into
// paddle-2 move levels and a serve pulse, with byte timeout and move hold timer.
//
// state      | meaning
// -----------+----------------------------------------------
// ST_IDLE    | hunting for the header byte
// ST_GOT_HDR | header seen, next byte is the command
// ST_GOT_CMD | command latched, next byte is its checksum
module uart_cmd_decoder #(
    parameter logic [7:0] HDR_BYTE     = 8'hA5,
    parameter int         BYTE_TIMEOUT = 20000,
    parameter int         HOLD_CYCLES  = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_dv,
    input  logic [7:0] rx_byte,
    output logic       move_up,
    output logic       move_down,
    output logic       serve,
    output logic       cmd_valid,
    output logic [7:0] last_cmd,
    output logic [7:0] err_count
);

    localparam int GW = $clog2(BYTE_TIMEOUT) + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;

    localparam logic [GW-1:0] GAP_LAST  = GW'(BYTE_TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GOT_HDR = 2'd1;
    localparam logic [1:0] ST_GOT_CMD = 2'd2;

    localparam logic [7:0] CMD_STOP  = 8'h00;
    localparam logic [7:0] CMD_UP    = 8'h01;
    localparam logic [7:0] CMD_DOWN  = 8'h02;
    localparam logic [7:0] CMD_SERVE = 8'h03;

    logic [1:0]    r_state;
    logic [7:0]    r_cmd;
    logic [GW-1:0] r_gap;
    logic [HW-1:0] r_hold;
    logic          r_move_up;
    logic          r_move_down;
    logic          r_serve;
    logic          r_cmd_valid;
    logic [7:0]    r_last_cmd;
    logic [7:0]    r_err_count;

    logic w_in_pkt;
    logic w_timeout;
    logic w_chk_byte;
    logic w_chk_ok;
    logic w_known;
    logic w_accept;
    logic w_pkt_err;
    logic w_err_inc;
    logic w_cmd_stop;
    logic w_cmd_up;
    logic w_cmd_down;
    logic w_cmd_serve;

    assign w_in_pkt   = (r_state != ST_IDLE);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign w_timeout  = w_in_pkt && !rx_dv && (r_gap == GAP_LAST);
    assign w_chk_byte = rx_dv && (r_state == ST_GOT_CMD);
    assign w_chk_ok   = (rx_byte == ~r_cmd);
    assign w_known    = (r_cmd <= CMD_SERVE);
    assign w_accept   = w_chk_byte && w_chk_ok && w_known;
    assign w_pkt_err  = w_chk_byte && !(w_chk_ok && w_known);
    assign w_err_inc  = w_pkt_err || w_timeout;

    assign w_cmd_stop  = w_accept && (r_cmd == CMD_STOP);
    assign w_cmd_up    = w_accept && (r_cmd == CMD_UP);
    assign w_cmd_down  = w_accept && (r_cmd == CMD_DOWN);
    assign w_cmd_serve = w_accept && (r_cmd == CMD_SERVE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cmd   <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_dv && (rx_byte == HDR_BYTE)) begin
                        r_state <= ST_GOT_HDR;
                    end
                end
                ST_GOT_HDR: begin
                    if (rx_dv) begin
                        r_cmd   <= rx_byte;
                        r_state <= ST_GOT_CMD;
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_GOT_CMD: begin
                    if (rx_dv || w_timeout) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gap <= '0;
        end else if (!w_in_pkt || rx_dv || w_timeout) begin
            r_gap <= '0;
        end else begin
            r_gap <= r_gap + 1'b1;
        end
    end

    // Accepted moves reload the hold timer; a lapsed timer drops both levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold      <= '0;
            r_move_up   <= 1'b0;
            r_move_down <= 1'b0;
        end else if (w_cmd_up) begin
            r_hold      <= HOLD_LOAD;
            r_move_up   <= 1'b1;
            r_move_down <= 1'b0;
        end else if (w_cmd_down) begin
            r_hold      <= HOLD_LOAD;
            r_move_up   <= 1'b0;
            r_move_down <= 1'b1;
        end else if (w_cmd_stop) begin
            r_hold      <= '0;
            r_move_up   <= 1'b0;
            r_move_down <= 1'b0;
        end else if (r_hold != '0) begin
            r_hold <= r_hold - 1'b1;
            if (r_hold == HW'(1)) begin
                r_move_up   <= 1'b0;
                r_move_down <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_serve     <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_last_cmd  <= 8'h00;
        end else begin
            r_serve     <= w_cmd_serve;
            r_cmd_valid <= w_accept;
            if (w_accept) begin
                r_last_cmd <= r_cmd;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_count <= 8'h00;
        end else if (w_err_inc && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'h01;
        end
    end

    assign move_up   = r_move_up;
    assign move_down = r_move_down;
    assign serve     = r_serve;
    assign cmd_valid = r_cmd_valid;
    assign last_cmd  = r_last_cmd;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder with short timeout/hold parameters;
// inputs change and outputs are sampled on the falling clock edge.
module tb_uart_cmd_decoder;

    logic       clk;
    logic       reset_n;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       move_up;
    logic       move_down;
    logic       serve;
    logic       cmd_valid;
    logic [7:0] last_cmd;
    logic [7:0] err_count;

    int n_checks;
    int n_fails;

    uart_cmd_decoder #(
        .HDR_BYTE    (8'hA5),
        .BYTE_TIMEOUT(16),
        .HOLD_CYCLES (100)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_dv    (rx_dv),
        .rx_byte  (rx_byte),
        .move_up  (move_up),
        .move_down(move_down),
        .serve    (serve),
        .cmd_valid(cmd_valid),
        .last_cmd (last_cmd),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; returns on the next falling edge, by which
    // time the byte has been captured and its registered effects are visible.
    task automatic pulse(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic packet(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        pulse(a);
        gap(4);
        pulse(b);
        gap(4);
        pulse(c);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        gap(2);
        reset_n = 1'b1;
        gap(1);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset_n  = 1'b0;
        rx_dv    = 1'b0;
        rx_byte  = 8'h00;
        #1;
        check1("rst_move_up", move_up, 1'b0);
        check1("rst_move_down", move_down, 1'b0);
        check1("rst_serve", serve, 1'b0);
        check1("rst_cmd_valid", cmd_valid, 1'b0);
        check8("rst_last_cmd", last_cmd, 8'h00);
        check8("rst_err_count", err_count, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        gap(1);

        // UP packet, then hold expiry exactly 100 cycles after it took effect
        packet(8'hA5, 8'h01, 8'hFE);
        check1("up_move_up", move_up, 1'b1);
        check1("up_move_down", move_down, 1'b0);
        check1("up_cmd_valid", cmd_valid, 1'b1);
        check8("up_last_cmd", last_cmd, 8'h01);
        gap(1);
        check1("up_cmd_valid_pulse", cmd_valid, 1'b0);
        gap(98);
        check1("hold_99", move_up, 1'b1);
        gap(1);
        check1("hold_100", move_up, 1'b0);
        check8("up_err_count", err_count, 8'h00);

        // DOWN then STOP 40 cycles later
        gap(2);
        packet(8'hA5, 8'h02, 8'hFD);
        check1("down_move_down", move_down, 1'b1);
        check1("down_move_up", move_up, 1'b0);
        gap(40);
        check1("down_held", move_down, 1'b1);
        packet(8'hA5, 8'h00, 8'hFF);
        check1("stop_move_down", move_down, 1'b0);
        check1("stop_move_up", move_up, 1'b0);
        check1("stop_cmd_valid", cmd_valid, 1'b1);
        check8("stop_last_cmd", last_cmd, 8'h00);

        // bad checksum, then unknown command
        gap(4);
        packet(8'hA5, 8'h01, 8'h00);
        check1("badchk_cmd_valid", cmd_valid, 1'b0);
        check1("badchk_move_up", move_up, 1'b0);
        check8("badchk_err", err_count, 8'h01);
        gap(4);
        packet(8'hA5, 8'h07, 8'hF8);
        check1("unk_cmd_valid", cmd_valid, 1'b0);
        check8("unk_err", err_count, 8'h02);
        check8("unk_last_cmd", last_cmd, 8'h00);

        // byte timeout, orphan bytes, then SERVE
        do_reset();
        pulse(8'hA5);
        gap(4);
        pulse(8'h01);
        gap(10);
        check8("to_not_yet", err_count, 8'h00);
        gap(10);
        check8("to_err", err_count, 8'h01);
        pulse(8'h01);
        gap(4);
        pulse(8'hFE);
        check1("orphan_cmd_valid", cmd_valid, 1'b0);
        check1("orphan_move_up", move_up, 1'b0);
        check8("orphan_err", err_count, 8'h01);
        gap(4);
        packet(8'hA5, 8'h03, 8'hFC);
        check1("serve_pulse", serve, 1'b1);
        check1("serve_cmd_valid", cmd_valid, 1'b1);
        check8("serve_last_cmd", last_cmd, 8'h03);
        check1("serve_move_up", move_up, 1'b0);
        check1("serve_move_down", move_down, 1'b0);
        gap(1);
        check1("serve_one_cycle", serve, 1'b0);

        // header byte used as command is unknown
        do_reset();
        pulse(8'h3C);
        gap(4);
        packet(8'hA5, 8'hA5, 8'h5A);
        check1("hdrcmd_cmd_valid", cmd_valid, 1'b0);
        check8("hdrcmd_err", err_count, 8'h01);
        gap(4);
        packet(8'hA5, 8'h01, 8'hFE);
        check1("resync_move_up", move_up, 1'b1);
        check1("resync_cmd_valid", cmd_valid, 1'b1);
        check8("resync_last_cmd", last_cmd, 8'h01);

        // asynchronous reset mid-hold and mid-packet
        gap(4);
        pulse(8'hA5);
        gap(2);
        #2;
        reset_n = 1'b0;
        #1;
        check1("arst_move_up", move_up, 1'b0);
        check1("arst_cmd_valid", cmd_valid, 1'b0);
        check8("arst_last_cmd", last_cmd, 8'h00);
        check8("arst_err", err_count, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        gap(1);
        pulse(8'h01);
        gap(4);
        pulse(8'hFE);
        check1("arst_partial_dropped", cmd_valid, 1'b0);
        check8("arst_partial_err", err_count, 8'h00);

        // error counter saturation
        for (int i = 0; i < 254; i++) begin
            gap(4);
            packet(8'hA5, 8'h01, 8'h00);
        end
        check8("sat_254", err_count, 8'hFE);
        gap(4);
        packet(8'hA5, 8'h01, 8'h00);
        check8("sat_255", err_count, 8'hFF);
        for (int i = 0; i < 45; i++) begin
            gap(4);
            packet(8'hA5, 8'h01, 8'h00);
        end
        check8("sat_300", err_count, 8'hFF);
        check1("sat_move_up", move_up, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Sits directly downstream of the UART receiver (uart_rx). It consumes the receiver's byte-valid pulse and received byte.
- Parses 3-byte framed command packets: header, command, checksum.
- Drives paddle-2 movement levels and a serve pulse, replacing the raw rx_byte[1:0] bit taps.
- Adds framing, error counting and a hold timeout, so a lost link stops the paddle instead of freezing it in motion.

Parameters:
- HDR_BYTE, 8'hA5, packet header value.
- BYTE_TIMEOUT, 20000, clk cycles allowed between bytes of one packet (2 ms at 10 MHz).
- HOLD_CYCLES, 1000000, clk cycles a move command stays active without refresh (100 ms at 10 MHz).

Ports:
- clk  in  1  receiver clock domain (clk_10).
- reset_n  in  1  asynchronous active-low reset.
- rx_dv  in  1  one-cycle pulse per received byte, from uart_rx o_Rx_DV.
- rx_byte  in  8  received byte; valid only while rx_dv=1.
- move_up  out  1  level; paddle-2 up request.
- move_down  out  1  level; paddle-2 down request.
- serve  out  1  one-cycle pulse; serve or start request.
- cmd_valid  out  1  one-cycle pulse per accepted packet.
- last_cmd  out  8  command byte of the most recently accepted packet.
- err_count  out  8  saturating count of framing, checksum, unknown-command and timeout errors.

Behaviour:
- Reset, asynchronous on reset_n low:
  - move_up, move_down, serve and cmd_valid = 0.
  - last_cmd = 8'h00; err_count = 0.
  - FSM = IDLE; all counters = 0.
- FSM states: IDLE, GOT_HDR, GOT_CMD. Every transition happens only on a cycle with rx_dv=1, except timeout.
- IDLE:
  - rx_dv with rx_byte==HDR_BYTE -> GOT_HDR.
  - Any other byte is ignored (resync), with no error.
- GOT_HDR: rx_dv -> latch cmd_reg=rx_byte, go to GOT_CMD. A byte equal to HDR_BYTE is latched as the command like any other.
- GOT_CMD: rx_dv -> go to IDLE.
  - If rx_byte == ~cmd_reg and cmd_reg is known: the packet is accepted.
  - If the checksum fails, or the command is unknown: err_count+1; outputs unchanged.
- Known commands:
  - 8'h00 STOP: move_up=move_down=0; hold counter cleared.
  - 8'h01 UP: move_up=1, move_down=0; hold counter loaded with HOLD_CYCLES.
  - 8'h02 DOWN: move_down=1, move_up=0; hold counter loaded with HOLD_CYCLES.
  - 8'h03 SERVE: serve pulses for 1 cycle; movement unaffected.
- Accepted packet effects:
  - cmd_valid pulses for 1 cycle and last_cmd updates.
  - Latency: all effects are registered and appear on the cycle after the checksum rx_dv.
- Byte timeout:
  - In GOT_HDR or GOT_CMD, a gap counter increments each cycle without rx_dv and is cleared by rx_dv.
  - When the counter reaches BYTE_TIMEOUT-1: FSM -> IDLE and err_count+1.
  - rx_dv on the expiry cycle wins: the byte is processed and no timeout error is counted.
  - The gap counter is idle (0) in IDLE.
- Hold timer:
  - Nonzero while a move is active; decrements by 1 per cycle.
  - On the cycle it goes 1->0, move_up and move_down clear.
  - A new UP/DOWN accepted on the expiry cycle wins: reload and keep or switch direction.
  - A repeated same-direction command reloads the timer with no output glitch.
- Invariants:
  - move_up and move_down are never both 1.
  - serve and cmd_valid are never high for 2 consecutive cycles unless 2 packets complete on consecutive cycles, which is impossible at the UART byte rate.
- err_count: saturates at 8'hFF; never wraps. Two error sources cannot coincide in one cycle.
- Counter widths: $clog2 of the respective parameter + 1; no overflow is permitted.
- Reset mid-packet or mid-hold: immediate return to reset values; a partial packet is discarded.

Test Plan (HDR_BYTE=A5, BYTE_TIMEOUT=16, HOLD_CYCLES=100, bytes spaced 5 cycles apart):
- Send A5,01,FE -> cycle after the 3rd rx_dv: move_up=1, cmd_valid=1 for 1 cycle, last_cmd=01; move_up falls exactly 100 cycles later; err_count=0.
- Send A5,02,FD then, 40 cycles later, A5,00,FF -> move_down=1 from the first packet, cleared the cycle after the STOP checksum; move_up stays 0 throughout.
- Send A5,01,00 (bad checksum) then A5,07,F8 (unknown command) -> no movement, no cmd_valid; err_count=2.
- Send A5,01 then idle 16 cycles -> FSM returns to IDLE and err_count=1. Then send 01,FE -> ignored, no error. Then send A5,03,FC -> serve pulses 1 cycle, moves unchanged.
- Send 3C,A5,A5,5A -> accepted? No: A5 is an unknown command, so err_count=1 and FSM is back in IDLE. Then A5,01,FE -> accepted normally.
- Assert reset_n=0 asynchronously mid-hold (move_up=1) and mid-packet -> all outputs 0 immediately. Then force 300 bad-checksum packets -> err_count saturates at FF.
